// File: rtl/pc_fetch_if.sv
// Fetch-sequencer bus: control/branch inputs, instruction-memory req/ack and fetch results.
// Handshake: imem_req is held with a stable imem_addr until imem_ack; an ack seen while imem_req=0 is ignored.
interface pc_fetch_if #(
   parameter int WIDTH_PC = 32
);
   logic                stall;
   logic                halt;
   logic                branch_taken;
   logic [WIDTH_PC-1:0] branch_target;
   logic                jump;
   logic [WIDTH_PC-1:0] jump_target;
   logic                imem_req;
   logic [WIDTH_PC-1:0] imem_addr;
   logic                imem_ack;
   logic [WIDTH_PC-1:0] pc;
   logic                fetch_valid;
   logic [WIDTH_PC-1:0] fetch_pc;
   logic                timeout_err;
   logic                align_err;

   modport master (
      input  stall, halt, branch_taken, branch_target, jump, jump_target, imem_ack,
      output imem_req, imem_addr, pc, fetch_valid, fetch_pc, timeout_err, align_err
   );

   modport slave (
      output stall, halt, branch_taken, branch_target, jump, jump_target, imem_ack,
      input  imem_req, imem_addr, pc, fetch_valid, fetch_pc, timeout_err, align_err
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer (BOOT/FETCH/WAIT/HOLD/HALT).
// Optional `define PC_ALIGN_CHECK_EN: flags misaligned redirect targets and forces target[1:0]=0.
module pc_fetch_sequencer #(
   parameter int                      WIDTH_PC    = 32,
   parameter logic [WIDTH_PC-1:0]     RESET_VEC   = '0,
   parameter int unsigned             ACK_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   pc_fetch_if.master   bus,
   output logic [2:0]   state_dbg_o
);

   localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_HALT  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [WIDTH_PC-1:0] pc_q, pc_d;
   logic [WIDTH_PC-1:0] fetch_pc_q, fetch_pc_d;
   logic [WIDTH_PC-1:0] pend_tgt_q, pend_tgt_d;
   logic                pend_q, pend_d;
   logic                fetch_valid_q, fetch_valid_d;
   logic                timeout_q, timeout_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                redir;
   logic [WIDTH_PC-1:0] tgt_raw;
   logic [WIDTH_PC-1:0] tgt;
   logic                halting;
   logic                req;
   logic                complete;
   logic [WIDTH_PC-1:0] redir_pc;

   assign redir   = bus.jump | bus.branch_taken;
   assign tgt_raw = bus.jump ? bus.jump_target : bus.branch_target;
`ifdef PC_ALIGN_CHECK_EN
   logic align_q, align_d;
   logic misaligned;
   assign tgt        = {tgt_raw[WIDTH_PC-1:2], 2'b00};
   assign misaligned = |tgt_raw[1:0];
`else
   assign tgt = tgt_raw;
`endif

   // Halt is honoured everywhere except BOOT and overrides any completion in the same cycle.
   assign halting  = bus.halt && (state_q inside {S_FETCH, S_WAIT, S_HOLD});
   assign req      = ((state_q == S_FETCH) && !bus.stall) || (state_q == S_WAIT);
   assign complete = req && bus.imem_ack && !halting;
   assign redir_pc = redir ? tgt : (pend_q ? pend_tgt_q : pc_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_BOOT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: begin
            if (complete)       state_d = S_FETCH;
            else if (bus.stall) state_d = S_HOLD;
            else                state_d = S_WAIT;
         end
         S_WAIT:  if (complete) state_d = bus.stall ? S_HOLD : S_FETCH;
         S_HOLD:  if (!bus.stall) state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_BOOT;
      endcase
      if (halting) state_d = S_HALT;
   end

   always_comb begin
      bus.imem_req = req;
      state_dbg_o  = state_q;
   end

   always_comb begin
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      pend_d        = pend_q;
      pend_tgt_d    = pend_tgt_q;
      fetch_valid_d = 1'b0;
      timeout_d     = timeout_q;
      cnt_d         = '0;
`ifdef PC_ALIGN_CHECK_EN
      align_d       = align_q;
`endif
      if ((state_q != S_HALT) && !halting) begin
`ifdef PC_ALIGN_CHECK_EN
         if (redir && misaligned) align_d = 1'b1;
`endif
         if (complete) begin
            // A pending redirect means the fetched word is off-path and must not be reported.
            fetch_pc_d    = pc_q;
            fetch_valid_d = !pend_q;
            pc_d          = redir ? tgt : (pend_q ? pend_tgt_q : pc_q + WIDTH_PC'(4));
            pend_d        = 1'b0;
         end else if ((state_q == S_HOLD) && !bus.stall) begin
            pc_d   = redir_pc;
            pend_d = 1'b0;
         end else if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt;
         end
         if ((state_q == S_WAIT) && !complete) begin
            cnt_d = cnt_q;
            if (cnt_q != TO_LIMIT) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == TO_LIMIT) timeout_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_VEC;
         fetch_pc_q    <= '0;
         pend_q        <= 1'b0;
         pend_tgt_q    <= '0;
         fetch_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         cnt_q         <= '0;
      end else begin
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         pend_q        <= pend_d;
         pend_tgt_q    <= pend_tgt_d;
         fetch_valid_q <= fetch_valid_d;
         timeout_q     <= timeout_d;
         cnt_q         <= cnt_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) align_q <= 1'b0;
      else        align_q <= align_d;
   end
   assign bus.align_err = align_q;
`else
   assign bus.align_err = 1'b0;
`endif

   assign bus.imem_addr   = pc_q;
   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_pc    = fetch_pc_q;
   assign bus.timeout_err = timeout_q;

endmodule
